// File: rtl/lpc_pkg.sv
// Shared LPC definitions: frame nibbles, SYNC codes and the host cycle state set.
// Kept separate so the device-side block can decode the same encodings.
package lpc_pkg;

   localparam logic [3:0] LPC_START   = 4'h0;
   localparam logic [3:0] CYC_IO_RD   = 4'h0;
   localparam logic [3:0] CYC_IO_WR   = 4'h2;
   localparam logic [3:0] LAD_IDLE    = 4'hF;

   localparam logic [3:0] SYNC_RDY      = 4'h0;
   localparam logic [3:0] SYNC_SHORT_WT = 4'h5;
   localparam logic [3:0] SYNC_LONG_WT  = 4'h6;
   localparam logic [3:0] SYNC_RDY_MORE = 4'h9;
   localparam logic [3:0] SYNC_ERR      = 4'hA;

   typedef enum logic [3:0] {
      IDLE,
      START,
      CYCTYPE,
      ADDR,
      WDATA,
      TAR_H,
      TAR_F,
      SYNC,
      RDATA,
      TAR_R,
      ABORT
   } lpc_state_e;

   function automatic logic sync_is_ready(input logic [3:0] nib);
      return (nib == SYNC_RDY) || (nib == SYNC_RDY_MORE);
   endfunction

endpackage

// File: rtl/lpc_host.sv
// LPC host for single-byte I/O read/write cycles, with SYNC wait handling,
// error reporting and a timeout abort. All bus outputs are registered.
module lpc_host
   import lpc_pkg::*;
#(
   parameter int SYNC_TIMEOUT = 32
) (
   input  logic        LPC_CLK,
   input  logic        LPC_RST,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [7:0]  resp_rdata,
   output logic        resp_err,
   output logic        LPC_FRAME,
   output logic [3:0]  LAD_OUT,
   output logic        LAD_OE,
   input  logic [3:0]  LAD_IN
);

   localparam logic [5:0] WAIT_LAST = 6'(SYNC_TIMEOUT - 1);

   lpc_state_e  state;
   logic        wr_q;
   logic        err_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic [1:0]  nib_idx;
   logic [5:0]  wait_cnt;

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         state      <= IDLE;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         nib_idx    <= '0;
         wait_cnt   <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         LPC_FRAME  <= 1'b1;
         LAD_OUT    <= LAD_IDLE;
         LAD_OE     <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wr_q      <= req_write;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  err_q     <= 1'b0;
                  req_ready <= 1'b0;
                  LPC_FRAME <= 1'b0;
                  LAD_OE    <= 1'b1;
                  LAD_OUT   <= LPC_START;
                  state     <= START;
               end
            end
            START: begin
               LPC_FRAME <= 1'b1;
               LAD_OUT   <= wr_q ? CYC_IO_WR : CYC_IO_RD;
               state     <= CYCTYPE;
            end
            CYCTYPE: begin
               LAD_OUT <= addr_q[15:12];
               nib_idx <= '0;
               state   <= ADDR;
            end
            // Address is shifted left so the next nibble is always at [11:8].
            ADDR: begin
               if (nib_idx == 2'd3) begin
                  nib_idx <= '0;
                  if (wr_q) begin
                     LAD_OUT <= wdata_q[3:0];
                     state   <= WDATA;
                  end else begin
                     LAD_OUT <= LAD_IDLE;
                     state   <= TAR_H;
                  end
               end else begin
                  LAD_OUT <= addr_q[11:8];
                  addr_q  <= {addr_q[11:0], 4'h0};
                  nib_idx <= nib_idx + 2'd1;
               end
            end
            WDATA: begin
               if (nib_idx == 2'd0) begin
                  LAD_OUT <= wdata_q[7:4];
                  nib_idx <= 2'd1;
               end else begin
                  LAD_OUT <= LAD_IDLE;
                  nib_idx <= '0;
                  state   <= TAR_H;
               end
            end
            TAR_H: begin
               LAD_OE <= 1'b0;
               state  <= TAR_F;
            end
            TAR_F: begin
               wait_cnt <= '0;
               state    <= SYNC;
            end
            SYNC: begin
               nib_idx <= '0;
               if (sync_is_ready(LAD_IN)) begin
                  state <= wr_q ? TAR_R : RDATA;
               end else if (LAD_IN == SYNC_ERR) begin
                  err_q <= 1'b1;
                  state <= TAR_R;
               end else if (wait_cnt == WAIT_LAST) begin
                  LPC_FRAME <= 1'b0;
                  LAD_OE    <= 1'b1;
                  LAD_OUT   <= LAD_IDLE;
                  state     <= ABORT;
               end else begin
                  wait_cnt <= wait_cnt + 6'd1;
               end
            end
            RDATA: begin
               if (nib_idx == 2'd0) begin
                  rdata_q[3:0] <= LAD_IN;
                  nib_idx      <= 2'd1;
               end else begin
                  rdata_q[7:4] <= LAD_IN;
                  nib_idx      <= '0;
                  state        <= TAR_R;
               end
            end
            TAR_R: begin
               if (nib_idx == 2'd0) begin
                  nib_idx <= 2'd1;
               end else begin
                  nib_idx    <= '0;
                  resp_valid <= 1'b1;
                  resp_err   <= err_q;
                  resp_rdata <= (err_q || wr_q) ? 8'h00 : rdata_q;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            ABORT: begin
               if (nib_idx == 2'd3) begin
                  nib_idx    <= '0;
                  LPC_FRAME  <= 1'b1;
                  LAD_OE     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 8'h00;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end else begin
                  nib_idx <= nib_idx + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: behavioural LPC target, table of I/O cycles with a
// response scoreboard, plus reset and busy-request sequences.
module tb_lpc_host;

   logic        LPC_CLK = 1'b0;
   logic        LPC_RST = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic        resp_err;
   logic        LPC_FRAME;
   logic [3:0]  LAD_OUT;
   logic        LAD_OE;
   logic [3:0]  LAD_IN = 4'hF;

   lpc_host #(.SYNC_TIMEOUT(32)) dut (
      .LPC_CLK(LPC_CLK), .LPC_RST(LPC_RST),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .LPC_FRAME(LPC_FRAME), .LAD_OUT(LAD_OUT), .LAD_OE(LAD_OE), .LAD_IN(LAD_IN)
   );

   always #5 LPC_CLK = ~LPC_CLK;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          waits;
      logic [3:0]  wcode;
      logic [3:0]  code;
      bit          present;
      logic [7:0]  data;
      bit          exp_err;
      logic [7:0]  exp_rdata;
      bit          chk_rdata;
      int          exp_lat;
   } vec_t;

   typedef struct {
      bit         err;
      logic [7:0] rdata;
      bit         chk_rdata;
      int         lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[11];
   int   errors = 0;
   int   checks = 0;

   // target behaviour for the cycle in flight
   bit         t_wr, t_present;
   int         t_waits;
   logic [3:0] t_wcode, t_code;
   logic [7:0] t_data;

   bit         active = 1'b0;
   int         k = 0;
   int         resp_cnt = 0;
   int         start_cnt = 0;
   logic [4:0] tr_lad[64];
   bit         tr_frame[64];
   int         m_sk, m_idx;
   exp_t       m_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Target model and response monitor, sampled mid-cycle.
   always @(negedge LPC_CLK) begin
      if (!LPC_RST) begin
         active = 1'b0;
         LAD_IN = 4'hF;
      end else begin
         if (!LPC_FRAME && LAD_OE && LAD_OUT == 4'h0) begin
            active = 1'b1;
            k = 0;
            start_cnt++;
         end else if (active) begin
            k++;
         end
         if (active && k < 64) begin
            tr_lad[k]   = LAD_OE ? {1'b0, LAD_OUT} : 5'h10;
            tr_frame[k] = LPC_FRAME;
         end
         LAD_IN = 4'hF;
         if (active && t_present) begin
            m_sk  = t_wr ? 10 : 8;
            m_idx = k - m_sk;
            if (m_idx >= 0) begin
               if (m_idx < t_waits) LAD_IN = t_wcode;
               else if (m_idx == t_waits) LAD_IN = t_code;
               else if (!t_wr && (t_code == 4'h0 || t_code == 4'h9)) begin
                  if (m_idx == t_waits + 1) LAD_IN = t_data[3:0];
                  else if (m_idx == t_waits + 2) LAD_IN = t_data[7:4];
               end
            end
         end
         if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               m_e = sb.pop_front();
               check("resp_err", {31'd0, resp_err}, {31'd0, m_e.err});
               if (m_e.chk_rdata) check("resp_rdata", {24'd0, resp_rdata}, {24'd0, m_e.rdata});
               check("latency", k, m_e.lat);
               check("ready_with_resp", {31'd0, req_ready}, 32'd1);
            end
            active = 1'b0;
         end
      end
   end

   task automatic set_target(input vec_t v);
      t_wr = v.wr; t_present = v.present; t_waits = v.waits;
      t_wcode = v.wcode; t_code = v.code; t_data = v.data;
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.err = v.exp_err; e.rdata = v.exp_rdata; e.chk_rdata = v.chk_rdata; e.lat = v.exp_lat;
      sb.push_back(e);
   endtask

   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [7:0] wdata);
      int n = 0;
      @(negedge LPC_CLK);
      while (!req_ready && n < 100) begin
         @(negedge LPC_CLK);
         n++;
      end
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      @(posedge LPC_CLK);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int target);
      int n = 0;
      while (resp_cnt < target && n < 200) begin
         @(posedge LPC_CLK);
         n++;
      end
      check("resp_arrived", {31'd0, resp_cnt >= target}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_frame"}, {31'd0, LPC_FRAME}, 32'd1);
      check({tag, "_oe"}, {31'd0, LAD_OE}, 32'd0);
      check({tag, "_lad"}, {28'd0, LAD_OUT}, 32'hF);
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      check({tag, "_rdata"}, {24'd0, resp_rdata}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] wr_seq[11];
      vec_t v;
      int rc, sc;

      // wr, addr, wdata, waits, wcode, code, present, data, exp_err, exp_rdata, chk_rdata, lat
      vecs[0]  = '{1'b1, 16'h03F8, 8'h41, 0,  4'h6, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 13};
      vecs[1]  = '{1'b0, 16'h03FD, 8'h00, 0,  4'h6, 4'h0, 1'b1, 8'h60, 1'b0, 8'h60, 1'b1, 13};
      vecs[2]  = '{1'b0, 16'h03FD, 8'h00, 3,  4'h6, 4'h0, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 16};
      vecs[3]  = '{1'b1, 16'h0080, 8'h55, 0,  4'h6, 4'hA, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 13};
      vecs[4]  = '{1'b1, 16'h0080, 8'hAA, 0,  4'h6, 4'h0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 46};
      vecs[5]  = '{1'b0, 16'h1234, 8'h00, 0,  4'h6, 4'h9, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 13};
      vecs[6]  = '{1'b0, 16'h2F00, 8'h00, 2,  4'h5, 4'h9, 1'b1, 8'hC3, 1'b0, 8'hC3, 1'b1, 15};
      vecs[7]  = '{1'b0, 16'h0064, 8'h00, 0,  4'h6, 4'hA, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 11};
      vecs[8]  = '{1'b0, 16'h0060, 8'h00, 0,  4'h6, 4'h0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 44};
      vecs[9]  = '{1'b0, 16'h0070, 8'h00, 1,  4'h3, 4'h0, 1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1, 14};
      vecs[10] = '{1'b1, 16'h0400, 8'h77, 31, 4'h6, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 44};
      wr_seq = '{5'h00, 5'h02, 5'h00, 5'h03, 5'h0F, 5'h08, 5'h01, 5'h04, 5'h0F, 5'h10, 5'h10};

      repeat (3) @(posedge LPC_CLK);
      #1 check_reset_outputs("reset");
      @(negedge LPC_CLK) LPC_RST = 1'b1;

      for (int i = 0; i < 11; i++) begin
         set_target(vecs[i]);
         push_exp(vecs[i]);
         rc = resp_cnt;
         do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         wait_resp(rc + 1);
         if (i == 0) begin
            for (int j = 0; j < 11; j++) check($sformatf("wr_lad_%0d", j), {27'd0, tr_lad[j]}, {27'd0, wr_seq[j]});
            check("start_frame_low", {31'd0, tr_frame[0]}, 32'd0);
            check("cyctype_frame_high", {31'd0, tr_frame[1]}, 32'd1);
         end
         if (i == 4) begin
            check("pre_abort_frame", {31'd0, tr_frame[41]}, 32'd1);
            for (int j = 42; j < 46; j++) begin
               check($sformatf("abort_frame_%0d", j), {31'd0, tr_frame[j]}, 32'd0);
               check($sformatf("abort_lad_%0d", j), {27'd0, tr_lad[j]}, 32'hF);
            end
         end
      end

      // request strobed mid-cycle must be dropped
      v = '{1'b0, 16'h0011, 8'h00, 0, 4'h6, 4'h0, 1'b1, 8'h11, 1'b0, 8'h11, 1'b1, 13};
      set_target(v);
      push_exp(v);
      rc = resp_cnt;
      do_req(v.wr, v.addr, v.wdata);
      repeat (4) @(posedge LPC_CLK);
      #1 begin req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hBEEF; end
      @(posedge LPC_CLK);
      #1 req_valid = 1'b0;
      wait_resp(rc + 1);
      sc = start_cnt;
      rc = resp_cnt;
      repeat (20) @(posedge LPC_CLK);
      check("busy_req_no_start", start_cnt, sc);
      check("busy_req_no_resp", resp_cnt, rc);

      // reset during ADDR, then immediate accept after release
      v = '{1'b0, 16'h5678, 8'h00, 0, 4'h6, 4'h0, 1'b1, 8'h99, 1'b0, 8'h99, 1'b1, 13};
      set_target(v);
      rc = resp_cnt;
      do_req(v.wr, v.addr, v.wdata);
      @(posedge LPC_CLK);
      @(posedge LPC_CLK);
      #2 LPC_RST = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (3) @(posedge LPC_CLK);
      check("midreset_no_resp", resp_cnt, rc);
      v.data = 8'h2B; v.exp_rdata = 8'h2B;
      set_target(v);
      push_exp(v);
      @(negedge LPC_CLK);
      LPC_RST = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h5678;
      @(posedge LPC_CLK);
      #1 req_valid = 1'b0;
      @(negedge LPC_CLK);
      #1 check("accept_after_release", {30'd0, LPC_FRAME, LAD_OE}, 32'd1);
      wait_resp(rc + 1);
      check("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 Parameter SYNC_TIMEOUT, default 32: number of SYNC clocks without a terminating code before the block aborts the cycle.
REQ-002 LPC_CLK  in  1  sole clock; all logic rising-edge.
REQ-003 LPC_RST  in  1  reset; asynchronous assert, active-low (0 = reset).
REQ-004 req_valid  in  1  host-side request strobe.
REQ-005 req_write  in  1  1 = I/O write, 0 = I/O read.
REQ-006 req_addr  in  16  I/O address.
REQ-007 req_wdata  in  8  write data.
REQ-008 req_ready  out  1  block idle, request accepted when req_valid&req_ready.
REQ-009 resp_valid  out  1  one-clock completion pulse.
REQ-010 resp_rdata  out  8  read data, held until next resp_valid.
REQ-011 resp_err  out  1  qualifies resp_valid; SYNC error or timeout.
REQ-012 LPC_FRAME  out  1  LFRAME#, active-low.
REQ-013 LAD_OUT  out  4  LAD nibble driven by host.
REQ-014 LAD_OE  out  1  LAD output enable (tri-state done at top level).
REQ-015 LAD_IN  in  4  LAD nibble sampled from bus.

Function
REQ-016 The FSM SHALL have states IDLE, START, CYCTYPE, ADDR, WDATA, TAR_H, TAR_F, SYNC, RDATA, TAR_R, ABORT.
REQ-017 IDLE: LPC_FRAME=1, LAD_OE=0, LAD_OUT=4'hF, req_ready=1; on accept, latch write/addr/wdata and go to START next clock.
REQ-018 START (1 clk): LPC_FRAME=0, LAD_OE=1, LAD_OUT=4'h0.
REQ-019 CYCTYPE (1 clk): LPC_FRAME=1, LAD_OUT=4'h2 for write, 4'h0 for read.
REQ-020 ADDR (4 clks): address nibbles driven most-significant first (addr[15:12] .. addr[3:0]).
REQ-021 WDATA (writes only, 2 clks): wdata[3:0] then wdata[7:4].
REQ-022 TAR_H (1 clk) drives 4'hF with LAD_OE=1; TAR_F (1 clk) LAD_OE=0; then SYNC.
REQ-023 SYNC: LAD_OE=0; sample LAD_IN each clock: 4'h0 or 4'h9 = ready; 4'h5/4'h6 = wait; 4'hA = error; any other value = wait.
REQ-024 SYNC ready on a read SHALL go to RDATA; RDATA samples 2 clks, LSN first, into resp_rdata.
REQ-025 SYNC ready on a write, or after RDATA, SHALL go to TAR_R (2 clks, LAD_OE=0, LAD_IN ignored), then IDLE.
REQ-026 SYNC error (4'hA) SHALL skip RDATA, go to TAR_R, and report resp_err=1, resp_rdata=8'h00.
REQ-027 A 6-bit wait counter SHALL clear on SYNC entry and increment each SYNC clock; at SYNC_TIMEOUT clocks without ready/error, go to ABORT.
REQ-028 ABORT: LPC_FRAME=0, LAD_OE=1, LAD_OUT=4'hF for 4 clocks, then IDLE with resp_err=1, resp_rdata=8'h00.
REQ-029 resp_valid SHALL pulse exactly one clock, on the clock IDLE is re-entered; req_ready is high in that same clock.
REQ-030 Minimum cycle length, START to IDLE, SHALL be 13 clocks for both read and write (SYNC ready on first sample).
REQ-031 req_valid outside IDLE SHALL be ignored; no queuing.

Reset
REQ-032 While LPC_RST=0: state=IDLE, LPC_FRAME=1, LAD_OE=0, LAD_OUT=4'hF, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=8'h00, counters 0.
REQ-033 Reset asserted mid-cycle SHALL abandon the cycle immediately with no resp_valid; the first accept SHALL be possible on the first clock after release.

Structure
REQ-034 Shared package lpc_pkg SHALL hold START/CYCTYPE nibble constants, SYNC code constants and the state enumeration, for reuse by lpc_dev.
REQ-035 Single module, no sub-modules; nibble index and wait counter in the same always block as the FSM.

Verification
REQ-036 Write addr 16'h03F8, data 8'h41, target SYNC 4'h0 -> LAD sequence 0,2,0,3,F,8,1,4,F,Z,Z; resp_valid, resp_err=0; total 13 clocks.
REQ-037 Read addr 16'h03FD, target SYNC 4'h0, data nibbles 4'h0,4'h6 -> resp_rdata=8'h60, resp_err=0.
REQ-038 Read with 3 clocks of SYNC 4'h6 then 4'h0, data 8'hA5 -> completion 3 clocks later than REQ-037; resp_rdata=8'hA5.
REQ-039 Write, target SYNC 4'hA -> no RDATA state, resp_err=1, resp_rdata=8'h00.
REQ-040 No target (LAD_IN=4'hF) -> 32 SYNC clocks, 4-clock ABORT with LPC_FRAME=0, LAD_OUT=4'hF, then resp_err=1.
REQ-041 LPC_RST asserted during ADDR -> outputs return to reset values asynchronously, no resp_valid; new request after release completes normally.
